// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
//   Definitions shared by both ends of the board-to-board UART link.
//   A frame is two bytes, high byte first: w[15:0] = {hi, lo}.
//     Position frame      : w[15:12] = tag, w[11:0] = value
//     Match-control frame : w[15:10] = MATCH_CTRL_HI, w[9] = end_game,
//                           w[8] = flag_point, w[7:4] = pl2_score,
//                           w[3:0] = pl1_score
//   Contents: tag constants, match-control pattern, receive FSM state enum,
//   and helpers that classify a candidate high byte.
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  localparam logic [3:0] TAG_PL1_POSX  = 4'h1;
  localparam logic [3:0] TAG_PL1_POSY  = 4'h2;
  localparam logic [3:0] TAG_BALL_POSX = 4'h5;
  localparam logic [3:0] TAG_BALL_POSY = 4'h6;

  localparam logic [5:0] MATCH_CTRL_HI = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_COMMIT  = 2'd2
  } frame_state_e;

  // Match-control shares tag nibble 1 with pl1_posx; the 6-bit pattern wins.
  function automatic logic is_match_ctrl(input logic [7:0] hi);
    return (hi[7:2] == MATCH_CTRL_HI);
  endfunction

  // A byte may open a frame only if it is match-control or carries a known
  // position tag. Everything else is dropped, which is how the receiver
  // regains byte alignment after a lost byte.
  function automatic logic is_accepted_hi(input logic [7:0] hi);
    logic ok;
    ok = 1'b0;
    if (is_match_ctrl(hi)) begin
      ok = 1'b1;
    end else begin
      case (hi[7:4])
        TAG_PL1_POSX, TAG_PL1_POSY,
        TAG_BALL_POSX, TAG_BALL_POSY: ok = 1'b1;
        default:                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/uart_demux.sv
// -----------------------------------------------------------------------------
// uart_demux
//   Receive-side frame decoder. Reassembles {hi, lo} byte pairs from the UART
//   RX core and writes the decoded fields into the game-state register bank.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles allowed between high and low byte of a frame
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rx_done      in   one-cycle strobe, rx_data holds a new byte
//   rx_data      in   [7:0] received byte
//   pl1_posx     out  [11:0] player-1 x position
//   pl1_posy     out  [11:0] player-1 y position
//   ball_posx    out  [11:0] ball x position
//   ball_posy    out  [11:0] ball y position
//   pl1_score    out  [3:0]  player-1 score
//   pl2_score    out  [3:0]  player-2 score
//   flag_point   out  point-scored flag
//   end_game     out  end-of-game flag
//   frame_valid  out  one-cycle strobe, a frame was committed this cycle
//   frame_err    out  one-cycle strobe, a partial frame timed out
// -----------------------------------------------------------------------------
module uart_demux
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  frame_state_e     r_state;
  logic [7:0]       r_hi;
  logic [7:0]       r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic [11:0]      r_pl1_posx;
  logic [11:0]      r_pl1_posy;
  logic [11:0]      r_ball_posx;
  logic [11:0]      r_ball_posy;
  logic [3:0]       r_pl1_score;
  logic [3:0]       r_pl2_score;
  logic             r_flag_point;
  logic             r_end_game;
  logic             r_frame_valid;
  logic             r_frame_err;

  logic             w_rx_hi_ok;
  logic [15:0]      w_word;
  logic             w_is_ctrl;
  logic [3:0]       w_tag;
  logic [11:0]      w_value;

  // Decode of the incoming byte (as a frame opener) and of the latched frame.
  always_comb begin
    w_rx_hi_ok = rx_done && is_accepted_hi(rx_data);
    w_word     = {r_hi, r_lo};
    w_is_ctrl  = is_match_ctrl(r_hi);
    w_tag      = w_word[15:12];
    w_value    = w_word[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hi          <= '0;
      r_lo          <= '0;
      r_cnt         <= '0;
      r_pl1_posx    <= '0;
      r_pl1_posy    <= '0;
      r_ball_posx   <= '0;
      r_ball_posy   <= '0;
      r_pl1_score   <= '0;
      r_pl2_score   <= '0;
      r_flag_point  <= 1'b0;
      r_end_game    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_rx_hi_ok) begin
            r_hi    <= rx_data;
            r_cnt   <= '0;
            r_state <= ST_WAIT_LO;
          end
        end

        // A low byte arriving on the last allowed cycle still completes the
        // frame: rx_done is tested before the timeout compare.
        ST_WAIT_LO: begin
          if (rx_done) begin
            r_lo    <= rx_data;
            r_state <= ST_COMMIT;
          end else if (r_cnt == CNT_LAST) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_COMMIT: begin
          r_frame_valid <= 1'b1;
          if (w_is_ctrl) begin
            r_end_game   <= w_word[9];
            r_flag_point <= w_word[8];
            r_pl2_score  <= w_word[7:4];
            r_pl1_score  <= w_word[3:0];
          end else begin
            case (w_tag)
              TAG_PL1_POSX:  r_pl1_posx  <= w_value;
              TAG_PL1_POSY:  r_pl1_posy  <= w_value;
              TAG_BALL_POSX: r_ball_posx <= w_value;
              TAG_BALL_POSY: r_ball_posy <= w_value;
              default: ;
            endcase
          end
          // A byte landing during the commit cycle opens the next frame so a
          // back-to-back stream loses nothing.
          if (w_rx_hi_ok) begin
            r_hi    <= rx_data;
            r_cnt   <= '0;
            r_state <= ST_WAIT_LO;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pl1_posx    = r_pl1_posx;
  assign pl1_posy    = r_pl1_posy;
  assign ball_posx   = r_ball_posx;
  assign ball_posy   = r_ball_posy;
  assign pl1_score   = r_pl1_score;
  assign pl2_score   = r_pl2_score;
  assign flag_point  = r_flag_point;
  assign end_game    = r_end_game;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_demux.sv
module tb_uart_demux;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, frame_valid, frame_err;

  uart_demux #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .pl1_posx   (pl1_posx),
    .pl1_posy   (pl1_posy),
    .ball_posx  (ball_posx),
    .ball_posy  (ball_posy),
    .pl1_score  (pl1_score),
    .pl2_score  (pl2_score),
    .flag_point (flag_point),
    .end_game   (end_game),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Strobe counters, sampled on the falling edge.
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_ferr++;
    if (frame_valid === 1'b1 && frame_err === 1'b1) n_both++;
  end

  logic [57:0] obs_state;
  assign obs_state = {pl1_posx, pl1_posy, ball_posx, ball_posy,
                      pl1_score, pl2_score, flag_point, end_game};

  // Reference model: game-state fields as the frame rules define them.
  logic [11:0] m_pl1x, m_pl1y, m_bx, m_by;
  logic [3:0]  m_s1, m_s2;
  logic        m_flag, m_end;

  function automatic logic [57:0] exp_state();
    return {m_pl1x, m_pl1y, m_bx, m_by, m_s1, m_s2, m_flag, m_end};
  endfunction

  function automatic void model_reset();
    m_pl1x = '0; m_pl1y = '0; m_bx = '0; m_by = '0;
    m_s1 = '0; m_s2 = '0; m_flag = 1'b0; m_end = 1'b0;
  endfunction

  function automatic bit model_hi_ok(input logic [7:0] b);
    return (b[7:2] == 6'b000111) || (b[7:4] == 4'd1) || (b[7:4] == 4'd2) ||
           (b[7:4] == 4'd5) || (b[7:4] == 4'd6);
  endfunction

  function automatic void model_frame(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = {hi, lo};
    if (w[15:10] == 6'b000111) begin
      m_end = w[9]; m_flag = w[8]; m_s2 = w[7:4]; m_s1 = w[3:0];
    end else if (w[15:12] == 4'd1) m_pl1x = w[11:0];
    else if (w[15:12] == 4'd2) m_pl1y = w[11:0];
    else if (w[15:12] == 4'd5) m_bx = w[11:0];
    else if (w[15:12] == 4'd6) m_by = w[11:0];
  endfunction

  function automatic logic [7:0] gen_hi();
    logic [7:0] b;
    case ($urandom_range(0, 3))
      0: begin
        case ($urandom_range(0, 3))
          0: b[7:4] = 4'd1;
          1: b[7:4] = 4'd2;
          2: b[7:4] = 4'd5;
          default: b[7:4] = 4'd6;
        endcase
        b[3:0] = 4'($urandom);
      end
      1: b = {6'b000111, 2'($urandom)};
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  // Drive a byte strobe on the falling edge; rx_done stays high until idle().
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (obs_state !== exp_state()) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", obs_state, exp_state());
    end
    n_checks++;
    if ({frame_valid, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 00", {frame_valid, frame_err});
    end
    n_checks++;
    if (n_valid + n_ferr != 0) begin
      n_err++; $display("FAIL reset_no_pulse: got %0d expected 0", n_valid + n_ferr);
    end
    rst = 1'b0;
  endtask

  task automatic test_position();
    int v0;
    v0 = n_valid;
    put(8'h13); idle(1); put(8'h20);
    idle(1);
    n_checks++;
    if (frame_valid !== 1'b0 || pl1_posx !== m_pl1x) begin
      n_err++; $display("FAIL pos_early: got valid=%b x=%h expected valid=0 x=%h",
                        frame_valid, pl1_posx, m_pl1x);
    end
    model_frame(8'h13, 8'h20);
    idle(1);
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_err++; $display("FAIL pos_latency: got valid=%b expected 1", frame_valid);
    end
    n_checks++;
    if (obs_state !== exp_state() || pl1_posx !== 12'h320) begin
      n_err++; $display("FAIL pos_state: got %h expected %h", obs_state, exp_state());
    end
    idle(1);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_err++; $display("FAIL pos_width: got valid=%b expected 0", frame_valid);
    end
    n_checks++;
    if (n_valid - v0 != 1) begin
      n_err++; $display("FAIL pos_count: got %0d expected 1", n_valid - v0);
    end
  endtask

  task automatic test_match_ctrl();
    int v0;
    v0 = n_valid;
    put(8'h1D); idle(1); put(8'h53); idle(4);
    model_frame(8'h1D, 8'h53);
    n_checks++;
    if (obs_state !== exp_state() ||
        {end_game, flag_point, pl2_score, pl1_score} !== 10'b0_1_0101_0011) begin
      n_err++; $display("FAIL ctrl_state: got %h expected %h", obs_state, exp_state());
    end
    n_checks++;
    if (n_valid - v0 != 1) begin
      n_err++; $display("FAIL ctrl_count: got %0d expected 1", n_valid - v0);
    end
  endtask

  task automatic test_resync();
    int v0, e0;
    v0 = n_valid; e0 = n_ferr;
    put(8'h3A); idle(1); put(8'h52); idle(1); put(8'h10); idle(4);
    model_frame(8'h52, 8'h10);
    n_checks++;
    if (obs_state !== exp_state() || ball_posx !== 12'h210) begin
      n_err++; $display("FAIL resync_state: got %h expected %h", obs_state, exp_state());
    end
    n_checks++;
    if (n_valid - v0 != 1 || n_ferr != e0) begin
      n_err++; $display("FAIL resync_count: got valid=%0d err=%0d expected 1 0",
                        n_valid - v0, n_ferr - e0);
    end
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = n_valid; e0 = n_ferr;
    put(8'h61); idle(T);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL tmo_early: got err=%b expected 0", frame_err);
    end
    idle(1);
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_err++; $display("FAIL tmo_pulse: got err=%b expected 1", frame_err);
    end
    idle(3);
    n_checks++;
    if (n_ferr - e0 != 1 || n_valid != v0 || obs_state !== exp_state()) begin
      n_err++; $display("FAIL tmo_drop: got err=%0d valid=%0d state=%h expected 1 0 %h",
                        n_ferr - e0, n_valid - v0, obs_state, exp_state());
    end
    put(8'h22); idle(1); put(8'h58); idle(4);
    model_frame(8'h22, 8'h58);
    n_checks++;
    if (obs_state !== exp_state() || pl1_posy !== 12'h258 || n_valid - v0 != 1) begin
      n_err++; $display("FAIL tmo_recover: got %h valid=%0d expected %h 1",
                        obs_state, n_valid - v0, exp_state());
    end
  endtask

  task automatic test_timeout_boundary();
    int v0, e0;
    // Low byte sampled on the last allowed cycle is accepted.
    v0 = n_valid; e0 = n_ferr;
    put(8'h62); idle(T - 1); put(8'h34); idle(1);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL bound_in_err: got err=%b expected 0", frame_err);
    end
    idle(4);
    model_frame(8'h62, 8'h34);
    n_checks++;
    if (obs_state !== exp_state() || n_valid - v0 != 1 || n_ferr != e0) begin
      n_err++; $display("FAIL bound_in: got %h valid=%0d err=%0d expected %h 1 0",
                        obs_state, n_valid - v0, n_ferr - e0, exp_state());
    end
    // One cycle later the frame is already dropped; 0x00 is then rejected.
    v0 = n_valid; e0 = n_ferr;
    put(8'h62); idle(T); put(8'h00); idle(5);
    n_checks++;
    if (obs_state !== exp_state() || n_valid != v0 || n_ferr - e0 != 1) begin
      n_err++; $display("FAIL bound_out: got %h valid=%0d err=%0d expected %h 0 1",
                        obs_state, n_valid - v0, n_ferr - e0, exp_state());
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    put(8'h13); put(8'h45); put(8'h51); put(8'h99); idle(5);
    model_frame(8'h13, 8'h45);
    model_frame(8'h51, 8'h99);
    n_checks++;
    if (obs_state !== exp_state() || n_valid - v0 != 2) begin
      n_err++; $display("FAIL b2b: got %h valid=%0d expected %h 2",
                        obs_state, n_valid - v0, exp_state());
    end
  endtask

  task automatic test_random();
    int v0, e0, nf, gap;
    bit pending;
    logic [7:0] b, hi_save;
    for (int k = 0; k < 6; k++) begin
      v0 = n_valid; e0 = n_ferr; nf = 0; pending = 1'b0; hi_save = '0;
      for (int i = 0; i < 14; i++) begin
        b = pending ? 8'($urandom) : gen_hi();
        gap = $urandom_range(0, 3);
        if (gap > 0) idle(gap);
        put(b);
        if (pending) begin
          model_frame(hi_save, b); pending = 1'b0; nf++;
        end else if (model_hi_ok(b)) begin
          pending = 1'b1; hi_save = b;
        end
      end
      if (pending) begin
        b = 8'($urandom);
        put(b);
        model_frame(hi_save, b); nf++;
      end
      idle(6);
      n_checks++;
      if (obs_state !== exp_state()) begin
        n_err++; $display("FAIL rand_state[%0d]: got %h expected %h", k, obs_state, exp_state());
      end
      n_checks++;
      if (n_valid - v0 != nf || n_ferr != e0) begin
        n_err++; $display("FAIL rand_count[%0d]: got valid=%0d err=%0d expected %0d 0",
                          k, n_valid - v0, n_ferr - e0, nf);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    put(8'h51); idle(1);
    rst = 1'b1;
    idle(1);
    model_reset();
    n_checks++;
    if (obs_state !== exp_state() || {frame_valid, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_clear: got %h %b expected %h 00",
                        obs_state, {frame_valid, frame_err}, exp_state());
    end
    rst = 1'b0;
    v0 = n_valid; e0 = n_ferr;
    put(8'h00); idle(5);
    n_checks++;
    if (obs_state !== exp_state() || n_valid != v0 || n_ferr != e0) begin
      n_err++; $display("FAIL rstmid_reject: got %h valid=%0d err=%0d expected %h 0 0",
                        obs_state, n_valid - v0, n_ferr - e0, exp_state());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_position();
    test_match_ctrl();
    test_resync();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    n_checks++;
    if (n_both != 0) begin
      n_err++; $display("FAIL strobe_overlap: got %0d expected 0", n_both);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
